// File: rtl/vdg_pkg.sv
// Shared widths, encodings and constants for the VDG-style text/graphics generator.
package vdg_pkg;
  localparam int unsigned LINE_W       = 8;
  localparam int unsigned COL_W        = 5;
  localparam int unsigned ADDR_W       = LINE_W + COL_W;
  localparam int unsigned GLYPH_ADDR_W = 10;
  localparam logic [7:0]  BLANK_BYTE   = 8'hFF;
  localparam logic        MODE_TEXT    = 1'b1;
  localparam logic        MODE_GFX     = 1'b0;
endpackage

// File: rtl/vdg_text_gen_if.sv
// Fetch-address / pixel-byte bus to the output stage plus the video RAM read port.
interface vdg_text_gen_if;
  import vdg_pkg::*;

  logic [ADDR_W-1:0] vga_address;
  logic [7:0]        vga_data;
  logic              settings;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  modport master (
    output vga_address, settings, ram_data,
    input  vga_data, ram_addr
  );

  modport slave (
    input  vga_address, settings, ram_data,
    output vga_data, ram_addr
  );
endinterface

// File: rtl/vdg_char_rom.sv
// 1024 x 8 synchronous glyph ROM, 16 rows per character, bit0 = leftmost pixel, 1 = ink.
module vdg_char_rom
  import vdg_pkg::*;
(
  input  logic                    clk,
  input  logic [GLYPH_ADDR_W-1:0] addr,
  output logic [7:0]              data
);

  logic [7:0] rom_d;

  // Built-in font subset; characters not listed render as blank cells.
  always_comb begin
    rom_d = 8'h00;
    case (addr)
      {6'h01, 4'd2}, {6'h01, 4'd5}:                 rom_d = (addr[3:0] == 4'd2) ? 8'h3C : 8'h7E;
      {6'h01, 4'd3}, {6'h01, 4'd4}, {6'h01, 4'd6},
      {6'h01, 4'd7}, {6'h01, 4'd8}:                 rom_d = 8'h66;
      {6'h02, 4'd2}, {6'h02, 4'd5}, {6'h02, 4'd8}:  rom_d = 8'h3E;
      {6'h02, 4'd3}, {6'h02, 4'd4}, {6'h02, 4'd6},
      {6'h02, 4'd7}:                                rom_d = 8'h66;
      default:                                      rom_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_d;
  end

endmodule

// File: rtl/vdg_text_gen.sv
// Converts output-stage fetch addresses into pixel bytes: 256x192 bitmap or 32x16 text cells.
module vdg_text_gen
  import vdg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SCREEN_BASE    = 13'h0000,
  parameter int unsigned       LINES_PER_CHAR = 12,
  parameter int unsigned       TEXT_ROWS      = 16
) (
  input  logic           clk,
  input  logic           reset,
  vdg_text_gen_if.slave  bus
);

  localparam int unsigned ACTIVE_LINES = TEXT_ROWS * LINES_PER_CHAR;

  // S0: address register, line tracker, mode register
  logic [ADDR_W-1:0] addr_q;
  logic              valid0_q;
  logic [3:0]        row_q, row_d, gline_q, gline_d;
  logic              mode_q, mode_d;
  // S1 / S2 / S3 side-band
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              text1_q, blank1_q, text2_q, blank2_q, text3_q, blank3_q;
  logic              text1_d, blank1_d;
  logic [3:0]        gline1_q, gline2_q;
  logic              inv3_q;
  logic [7:0]        gfx3_q;
  logic [7:0]        glyph;
  logic              unused_ram_bit6;

  logic [LINE_W-1:0] line_in;
  assign line_in = bus.vga_address[ADDR_W-1:COL_W];
  assign unused_ram_bit6 = bus.ram_data[6];

  always_comb begin
    row_d   = row_q;
    gline_d = gline_q;
    mode_d  = mode_q;
    if (line_in != addr_q[ADDR_W-1:COL_W]) begin
      if (line_in == '0) begin
        row_d   = '0;
        gline_d = '0;
        mode_d  = bus.settings;
      end else if (gline_q == 4'(LINES_PER_CHAR - 1)) begin
        gline_d = '0;
        row_d   = row_q + 4'd1;
      end else begin
        gline_d = gline_q + 4'd1;
      end
    end
  end

  always_comb begin
    text1_d    = (mode_q == MODE_TEXT);
    blank1_d   = !valid0_q ||
                 (text1_d && ({24'd0, addr_q[ADDR_W-1:COL_W]} >= ACTIVE_LINES));
    ram_addr_d = ram_addr_q;
    if (valid0_q) begin
      if (!text1_d) begin
        ram_addr_d = addr_q;
      end else if (!blank1_d) begin
        ram_addr_d = SCREEN_BASE + {4'd0, row_q, addr_q[COL_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      valid0_q   <= 1'b0;
      row_q      <= '0;
      gline_q    <= '0;
      mode_q     <= MODE_TEXT;
      ram_addr_q <= '0;
      text1_q    <= 1'b1;
      blank1_q   <= 1'b1;
      gline1_q   <= '0;
      text2_q    <= 1'b1;
      blank2_q   <= 1'b1;
      gline2_q   <= '0;
      text3_q    <= 1'b1;
      blank3_q   <= 1'b1;
      inv3_q     <= 1'b0;
      gfx3_q     <= BLANK_BYTE;
    end else begin
      addr_q     <= bus.vga_address;
      valid0_q   <= 1'b1;
      row_q      <= row_d;
      gline_q    <= gline_d;
      mode_q     <= mode_d;
      ram_addr_q <= ram_addr_d;
      text1_q    <= text1_d;
      blank1_q   <= blank1_d;
      gline1_q   <= gline_q;
      text2_q    <= text1_q;
      blank2_q   <= blank1_q;
      gline2_q   <= gline1_q;
      text3_q    <= text2_q;
      blank3_q   <= blank2_q;
      inv3_q     <= bus.ram_data[7];
      gfx3_q     <= bus.ram_data;
    end
  end

  // RAM data arrives during S2 and addresses the ROM directly; the ROM register is S3.
  vdg_char_rom u_char_rom (
    .clk  (clk),
    .addr ({bus.ram_data[5:0], gline2_q}),
    .data (glyph)
  );

  assign bus.ram_addr = ram_addr_q;
  assign bus.vga_data = blank3_q ? BLANK_BYTE :
                        text3_q  ? ~(glyph ^ {8{inv3_q}}) : gfx3_q;

endmodule
